alu_fifo_core_p: RTL

- Parametrised ALU block with buffered operand, opcode and result channels.
- Accepts operand A, operand B and opcode on three independent valid/ready channels, each into its own internal FIFO.
- Issues one operation per cycle when all three heads are present and result space is guaranteed, then buffers results in an output FIFO.
- Successor to the fixed single-entry ALU/FIFO top: depth, data width and opcode width are parameters; adds credit-based issue and XOR/pass-through modes.

---
 rtl/alu_fifo_core_p_if.sv | 24 ++
 rtl/alu_fifo_core_p.sv | 107 ++++++++++
 2 files changed

// File: rtl/alu_fifo_core_p_if.sv
// alu_fifo_core_p_if: operand/opcode input channels and result output channel, all valid/ready.
// master drives the inputs and consumes results; slave is the ALU core.
interface alu_fifo_core_p_if #(parameter int W = 8, parameter int OPW = 3);
   logic [W-1:0]   a_i;
   logic           a_valid_i;
   logic           a_ready_o;
   logic [W-1:0]   b_i;
   logic           b_valid_i;
   logic           b_ready_o;
   logic [OPW-1:0] op_i;
   logic           op_valid_i;
   logic           op_ready_o;
   logic [W:0]     out_o;
   logic           out_valid_o;
   logic           out_ready_i;
   modport master (
      output a_i, a_valid_i, b_i, b_valid_i, op_i, op_valid_i, out_ready_i,
      input  a_ready_o, b_ready_o, op_ready_o, out_o, out_valid_o
   );
   modport slave (
      input  a_i, a_valid_i, b_i, b_valid_i, op_i, op_valid_i, out_ready_i,
      output a_ready_o, b_ready_o, op_ready_o, out_o, out_valid_o
   );
endinterface

// File: rtl/alu_fifo_core_p.sv
// alu_fifo_core_p: ALU fed by A/B/opcode FIFOs, credit-gated issue stage, output result FIFO.
// Define ALU_FIFO_STATS_EN to add ops_done_o (output handshake count) and illegal_op_o (sticky).
module alu_fifo_core_p #(
   parameter int DATA_IN_WIDTH = 8,
   parameter int OPCODE_WIDTH  = 3,
   parameter int FIFO_DEPTH    = 4
) (
   input  logic clk_i,
   input  logic rst_i,
   alu_fifo_core_p_if.slave bus
`ifdef ALU_FIFO_STATS_EN
   ,
   output logic [15:0] ops_done_o,
   output logic        illegal_op_o
`endif
);
   localparam int W  = DATA_IN_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   typedef logic [OPCODE_WIDTH-1:0] op_t;
   // channel index: 0=A, 1=B, 2=opcode, 3=result
   logic [3:0][AW-1:0] r_wr;
   logic [3:0][AW-1:0] r_rd;
   logic [3:0][CW-1:0] r_cnt;
   logic [W-1:0]       r_mem_a   [FIFO_DEPTH];
   logic [W-1:0]       r_mem_b   [FIFO_DEPTH];
   op_t                r_mem_op  [FIFO_DEPTH];
   logic [W:0]         r_mem_out [FIFO_DEPTH];
   logic               r_stage_valid;
   logic [W:0]         r_stage_data;
   logic [3:0]         w_push;
   logic [3:0]         w_pop;
   logic [3:0]         w_full;
   logic [3:0]         w_nempty;
   logic               w_issue;
   logic [W:0]         w_ax;
   logic [W:0]         w_bx;
   op_t                w_op;
   logic [W:0]         w_alu;
   for (genvar i = 0; i < 4; i++) begin : g_flags
      assign w_full[i]   = r_cnt[i] == CW'(FIFO_DEPTH);
      assign w_nempty[i] = r_cnt[i] != '0;
   end
   assign bus.a_ready_o   = ~w_full[0];
   assign bus.b_ready_o   = ~w_full[1];
   assign bus.op_ready_o  = ~w_full[2];
   assign bus.out_valid_o = w_nempty[3];
   assign bus.out_o       = w_nempty[3] ? r_mem_out[r_rd[3]] : '0;
   // result space counts the in-flight stage entry so the output FIFO can never overflow
   assign w_issue = &w_nempty[2:0] && (r_cnt[3] + CW'(r_stage_valid) < CW'(FIFO_DEPTH));
   assign w_push  = {r_stage_valid, bus.op_valid_i & ~w_full[2], bus.b_valid_i & ~w_full[1],
                     bus.a_valid_i & ~w_full[0]};
   assign w_pop   = {bus.out_valid_o & bus.out_ready_i, {3{w_issue}}};
   assign w_ax    = {1'b0, r_mem_a[r_rd[0]]};
   assign w_bx    = {1'b0, r_mem_b[r_rd[1]]};
   assign w_op    = r_mem_op[r_rd[2]];
   assign w_alu   = (w_op == op_t'(0)) ? w_ax + w_bx :
                    (w_op == op_t'(1)) ? w_ax - w_bx :
                    (w_op == op_t'(2)) ? w_ax & w_bx :
                    (w_op == op_t'(3)) ? w_ax | w_bx :
                    (w_op == op_t'(4)) ? w_ax ^ w_bx :
                    (w_op == op_t'(5)) ? w_ax :
                    (w_op == op_t'(6)) ? w_bx : '0;
   always_ff @(posedge clk_i) begin
      for (int i = 0; i < 4; i++) begin
         if (rst_i) begin
            r_wr[i]  <= '0;
            r_rd[i]  <= '0;
            r_cnt[i] <= '0;
         end else begin
            if (w_push[i]) r_wr[i] <= r_wr[i] + 1'b1;
            if (w_pop[i]) r_rd[i] <= r_rd[i] + 1'b1;
            r_cnt[i] <= r_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
         end
      end
   end
   always_ff @(posedge clk_i) begin
      if (w_push[0]) r_mem_a[r_wr[0]] <= bus.a_i;
      if (w_push[1]) r_mem_b[r_wr[1]] <= bus.b_i;
      if (w_push[2]) r_mem_op[r_wr[2]] <= bus.op_i;
      if (w_push[3]) r_mem_out[r_wr[3]] <= r_stage_data;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_stage_valid <= 1'b0;
         r_stage_data  <= '0;
      end else begin
         r_stage_valid <= w_issue;
         if (w_issue) r_stage_data <= w_alu;
      end
   end
`ifdef ALU_FIFO_STATS_EN
   logic [15:0] r_ops_done;
   logic        r_illegal;
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_ops_done <= '0;
         r_illegal  <= 1'b0;
      end else begin
         if (w_pop[3]) r_ops_done <= r_ops_done + 1'b1;
         if (w_issue && w_op >= op_t'(7)) r_illegal <= 1'b1;
      end
   end
   assign ops_done_o   = r_ops_done;
   assign illegal_op_o = r_illegal;
`endif
endmodule
